// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the FIFO-fed UART transmitter.
//   uart_tx_state_t        - transmitter FSM state encoding
//   DEFAULT_DATA_WIDTH     - default payload bits per frame
//   DEFAULT_CLOCKS_PER_BIT - default clock cycles per serial bit
// Optional feature macro used by the transmitter: UART_TX_PARITY_EN.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
    localparam int unsigned DEFAULT_CLOCKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter for the UART transmitter.
// Ports:
//   clock   - single clock, posedge
//   reset   - asynchronous active-high reset
//   restart - hold the counter at 0 (between frames)
//   tick    - high on the last cycle of each bit period
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned clocks_per_bit = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = $clog2(clocks_per_bit);
    localparam logic [CW-1:0] LAST = CW'(clocks_per_bit - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pulls bytes from a registered-read FIFO.
// Frame: start(0), data LSB first, optional even parity, stop(1).
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
// Ports:
//   clock      - single clock, posedge
//   reset      - asynchronous active-high reset
//   fifo_data  - FIFO read data, valid the cycle after fifo_pop
//   fifo_empty - FIFO holds no entries
//   fifo_pop   - one-cycle request to remove the FIFO head (IDLE only)
//   tx         - serial line, idle high
//   busy       - high while a frame is loading or shifting
//   tx_done    - one-cycle pulse in the first IDLE cycle after a frame
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned data_width     = DEFAULT_DATA_WIDTH,
    parameter int unsigned clocks_per_bit = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [data_width-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned BW = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(data_width - 1);

    uart_tx_state_t        state_q, state_d;
    logic [data_width-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  done_q, done_d;
    logic                  pop_req;
    logic                  bit_tick;
    logic                  baud_restart;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // Counter is held at 0 until the start bit, so every bit gets a full period.
    assign baud_restart = (state_q == IDLE) || (state_q == LOAD);

    uart_baud_tick #(
        .clocks_per_bit(clocks_per_bit)
    ) u_baud (
        .clock  (clock),
        .reset  (reset),
        .restart(baud_restart),
        .tick   (bit_tick)
    );

    // Pop is combinational from IDLE; masking with reset keeps it low while
    // reset is held even though the state register already reads IDLE.
    assign fifo_pop = pop_req && !reset;
    assign tx_done  = done_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        pop_req   = 1'b0;
        tx        = 1'b1;
        busy      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (!fifo_empty) begin
                    pop_req = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                state_d  = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_q;
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: self-checking bench for fifo_uart_tx (data_width=8,
// clocks_per_bit=4). A small FIFO model feeds the DUT; expected line,
// pop, busy and tx_done values come from frame arithmetic on the pushed bytes.
// Honours UART_TX_PARITY_EN to expect the parity bit.
module tb_fifo_uart_tx;

    localparam int W = 8;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int P = 2 + (2 + W + PAR) * C;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_empty;
    logic         fifo_pop, tx, busy, tx_done;

    logic [7:0]   fmem [0:63];
    int unsigned  wr_ptr = 0;
    int unsigned  rd_ptr = 0;
    logic         tog = 1'b0;

    logic [7:0]   fb [0:7];
    int           nb = 0;
    int           total = 0;
    int           bad = 0;

    fifo_uart_tx #(
        .data_width    (W),
        .clocks_per_bit(C)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clock = ~clock;

    assign fifo_empty = (wr_ptr == rd_ptr) || tog;

    always @(posedge clock) begin
        if (fifo_pop) begin
            fifo_data <= fmem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s idx=%0d observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr[5:0]] = b;
        wr_ptr++;
        fb[nb] = b;
        nb++;
    endtask

    function automatic logic exp_tx(input int i);
        int k, o, j;
        logic [7:0] b;
        k = i / P;
        o = i % P;
        if (k >= nb || o < 2) return 1'b1;
        b = fb[k];
        j = (o - 2) / C;
        if (j == 0) return 1'b0;
        if (j <= W) return b[j-1];
        if (PAR == 1 && j == W + 1) return ^b;
        return 1'b1;
    endfunction

    // Caller is at a negedge with bytes already pushed; sample index 0 is
    // the expected pop cycle of the first byte.
    task automatic run_check(input string tag, input int ns, input int tlo, input int thi);
        int k, o;
        for (int i = 0; i < ns; i++) begin
            if (i > 0) @(negedge clock);
            tog = (i >= tlo && i < thi) ? ~tog : 1'b0;
            #1;
            k = i / P;
            o = i % P;
            chk({tag, ".tx"},   i, tx,       exp_tx(i));
            chk({tag, ".pop"},  i, fifo_pop, (k < nb) && (o == 0));
            chk({tag, ".busy"}, i, busy,     (k < nb) && (o != 0));
            chk({tag, ".done"}, i, tx_done,  (o == 0) && (k > 0) && (k <= nb));
        end
    endtask

    task automatic idle_check(input string tag, input int idx);
        chk({tag, ".tx"},   idx, tx,       1'b1);
        chk({tag, ".pop"},  idx, fifo_pop, 1'b0);
        chk({tag, ".busy"}, idx, busy,     1'b0);
        chk({tag, ".done"}, idx, tx_done,  1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with a non-empty FIFO: line idle, no pop.
        push(8'hA5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            idle_check("rst_hold", i);
        end

        // Release: the pending 0xA5 goes out.
        @(negedge clock);
        reset = 1'b0;
        run_check("a5", P + 6, 0, 0);

        // Back-to-back frames, order preserved.
        @(negedge clock);
        nb = 0;
        push(8'h01); push(8'h02); push(8'h03);
        run_check("seq3", 3 * P + 6, 0, 0);

        // Parity-sensitive bytes plus random payloads.
        @(negedge clock);
        nb = 0;
        push(8'h07); push(8'h03); push(8'($urandom)); push(8'($urandom));
        run_check("mix", 4 * P + 6, 0, 0);

        // fifo_empty toggling every cycle during the first frame.
        @(negedge clock);
        nb = 0;
        push(8'($urandom)); push(8'($urandom));
        run_check("tog", 2 * P + 6, 2, P - 3);

        // Reset in the middle of the data bits of 0xFF.
        @(negedge clock);
        nb = 0;
        push(8'hFF);
        run_check("pre_rst", 16, 0, 0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        idle_check("mid_rst", 0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            #1;
            idle_check("mid_rst", i);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            idle_check("post_rst", i);
        end

        // Normal operation after the aborted frame.
        @(negedge clock);
        nb = 0;
        push(8'($urandom));
        run_check("recover", P + 6, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
